layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised, pipelined pixel compositor that merges the maze wall, pellet, power-pellet and N sprite layers into a single RGB stream for the HDMI path. Colours come from a run-time writable palette. A frame-synchronous end-of-game state machine drives flash/tint effects, and a frame counter blinks power pellets. The block sits between the per-pixel layer generators (maze BRAM, pellet map, sprite engines) and the VGA-to-HDMI encoder.

## Interface
Parameters:
- NUM_SPRITES, 4: sprite layers; bit 0 has highest priority.
- COLOR_W, 4: bits per colour channel.
- WALL_LAT, 1: cycles by which wall_pixel lags the other inputs (BRAM read latency); range 0..3.
- BLINK_BIT, 4: frame-counter bit that gates power pellets.
- FLASH_PERIOD, 8: frames per flash phase.
- FLASH_FRAMES, 64: total flash duration in frames before hold.

Ports:
- clk_25MHz  in  1  pixel clock.
- reset_n  in  1  reset; asynchronous, active-low.
- frame_start  in  1  one-cycle pulse on the first pixel of each frame.
- active  in  1  pixel is in the visible region.
- in_maze  in  1  pixel lies inside the maze area.
- wall_pixel  in  1  wall bit for the pixel presented WALL_LAT cycles earlier.
- pellet_pixel  in  1  pellet present.
- power_pixel  in  1  power pellet present.
- sprite_pixel  in  NUM_SPRITES  per-sprite coverage.
- win, game_over  in  1 each  level game status.
- pal_we  in  1  palette write strobe.
- pal_addr  in  $clog2(NUM_SPRITES+4)  palette entry.
- pal_data  in  3*COLOR_W  {R,G,B}.
- Red, Green, Blue  out  COLOR_W each  registered colour.
- state  out  2  effect state: 0 PLAY, 1 FLASH, 2 HOLD.

## Operation
- Palette entries: 0 background, 1 wall, 2 pellet, 3 power, 4+i sprite i.
- Palette reset values: 000, 00F, 0F0, FFF, then sprites F00, FF0, F0F, 0FF, repeating, all scaled to COLOR_W.
- A palette write takes effect at the next clock edge. A pixel registered on that same edge uses the old value.
- Every input except wall_pixel is delayed WALL_LAT cycles so it aligns with the wall bit.
- Priority in PLAY:
  - Lowest set sprite bit.
  - Wall.
  - Power pellet, only when frame_cnt[BLINK_BIT]==0.
  - Pellet.
  - Background.
- Pellet and power are ignored when the wall bit is set.
- When in_maze=0, the layer result is background. When active=0, the output is 0 in every state.
- Foreground means any sprite, wall, pellet or visible power bit.
- Tint colours (all channels scaled to COLOR_W):
  - win: foreground 0F0, background 040.
  - lose: foreground F00, background 400.
  - win has priority over game_over.
- frame_cnt: 8-bit, increments on each frame_start, wraps 255→0, reset 0.
- State machine; all transitions are evaluated only on frame_start:
  - PLAY→FLASH when win|game_over. flash_cnt is cleared.
  - In FLASH, output is tinted when flash_cnt/FLASH_PERIOD is odd, otherwise it is the normal composite. flash_cnt increments each frame.
  - FLASH→HOLD when flash_cnt reaches FLASH_FRAMES-1. In HOLD the tint is constant.
  - FLASH or HOLD→PLAY when win and game_over are both 0 at frame_start.
  - The tint colour tracks the live win/game_over value during FLASH and HOLD. If win rises while in FLASH, the tint switches to green and the flash timing does not restart.

## Timing
- Reset values: Red, Green, Blue = 0; state = PLAY; frame_cnt = 0; flash_cnt = 0; palette at its defaults; delay line cleared.
- Latency: inputs for pixel P presented at cycle t (wall_pixel at t+WALL_LAT) produce RGB at t+WALL_LAT+1. Throughput is one pixel per clock with no stalls.
- frame_start is delayed together with the pixel data, so a state change first affects the first pixel of the new frame exactly.
- The state output updates one cycle after frame_start is sampled.
- Reset asserted mid-frame forces outputs to 0 immediately (asynchronously). Compositing resumes on the first clock after release. The state machine stays in PLAY until the next frame_start.
- pal_we held high for several cycles performs one write per cycle. The last write wins.

## Test plan
- Priority: drive sprite_pixel=4'b0110 with wall=1 and pellet=1 after reset → output is sprite1 colour FF0, 1+WALL_LAT cycles later. Drive sprite_pixel=0 with wall=1 → 00F.
- Latency: with WALL_LAT=2, a single-cycle wall pulse aligned to a 1-pixel pellet → 00F appears at exactly t+3. Pellet green must never appear on the wall pixel.
- Blink: hold power_pixel=1 for 40 frames with BLINK_BIT=4 → FFF during frames 0-15, background during 16-31, FFF again from frame 32.
- Win flash: raise win mid-frame at frame 10 → state=FLASH at the next frame_start. Frames 8-15 of the flash show wall as 0F0 and background as 040. state=HOLD after 64 frames. Clearing win → PLAY at the following frame_start.
- Palette: write addr 1 = 0A5 on the same cycle a wall pixel is registered → that pixel shows 00F, and the next wall pixel shows 0A5.
- Reset: assert reset_n=0 in HOLD mid-line → RGB is 0 immediately. After release, state is PLAY and the palette is back at its defaults.

Source files
------------

// File: rtl/layer_compositor.sv
// Pipelined pixel compositor: merges wall, pellet, power-pellet and sprite layers through a
// writable palette, aligns everything to the late wall bit, and applies end-of-game flash/tint.
module layer_compositor #(
    parameter int NUM_SPRITES  = 4,
    parameter int COLOR_W      = 4,
    parameter int WALL_LAT     = 1,
    parameter int BLINK_BIT    = 4,
    parameter int FLASH_PERIOD = 8,
    parameter int FLASH_FRAMES = 64
) (
    input  logic                               clk_25MHz,
    input  logic                               reset_n,
    input  logic                               frame_start,
    input  logic                               active,
    input  logic                               in_maze,
    input  logic                               wall_pixel,
    input  logic                               pellet_pixel,
    input  logic                               power_pixel,
    input  logic [NUM_SPRITES-1:0]             sprite_pixel,
    input  logic                               win,
    input  logic                               game_over,
    input  logic                               pal_we,
    input  logic [$clog2(NUM_SPRITES+4)-1:0]   pal_addr,
    input  logic [3*COLOR_W-1:0]               pal_data,
    output logic [COLOR_W-1:0]                 Red,
    output logic [COLOR_W-1:0]                 Green,
    output logic [COLOR_W-1:0]                 Blue,
    output logic [1:0]                         state
);
    localparam int NUM_PAL = NUM_SPRITES + 4;
    localparam int ADDR_W  = $clog2(NUM_PAL);
    localparam int PIX_W   = 3 * COLOR_W;
    localparam int BUN_W   = NUM_SPRITES + 7;
    localparam int FC_W    = $clog2(FLASH_FRAMES + 1);
    localparam int REP     = (COLOR_W + 3) / 4;

    typedef enum logic [1:0] {PLAY = 2'd0, FLASH = 2'd1, HOLD = 2'd2} state_t;

    // Nibble colours are stretched by MSB-first replication so F stays full scale at any width.
    function automatic logic [COLOR_W-1:0] scale4(input logic [3:0] n);
        logic [4*REP-1:0] rep;
        rep = {REP{n}};
        return rep[4*REP-1 -: COLOR_W];
    endfunction

    function automatic logic [PIX_W-1:0] rgb12(input logic [11:0] c);
        return {scale4(c[11:8]), scale4(c[7:4]), scale4(c[3:0])};
    endfunction

    function automatic logic [PIX_W-1:0] pal_default(input int idx);
        logic [11:0] c;
        case (idx)
            0:       c = 12'h000;
            1:       c = 12'h00F;
            2:       c = 12'h0F0;
            3:       c = 12'hFFF;
            default: begin
                case ((idx - 4) % 4)
                    0:       c = 12'hF00;
                    1:       c = 12'hFF0;
                    2:       c = 12'hF0F;
                    default: c = 12'h0FF;
                endcase
            end
        endcase
        return rgb12(c);
    endfunction

    localparam logic [PIX_W-1:0] TINT_WIN_FG  = rgb12(12'h0F0);
    localparam logic [PIX_W-1:0] TINT_WIN_BG  = rgb12(12'h040);
    localparam logic [PIX_W-1:0] TINT_LOSE_FG = rgb12(12'hF00);
    localparam logic [PIX_W-1:0] TINT_LOSE_BG = rgb12(12'h400);

    logic [BUN_W-1:0]       bundle;
    logic [BUN_W-1:0]       dly;
    logic                   d_fs, d_active, d_in_maze, d_pellet, d_power, d_win, d_go;
    logic [NUM_SPRITES-1:0] d_sprite;

    logic [PIX_W-1:0]  pal_reg [NUM_PAL];
    state_t            state_reg, state_next;
    logic [7:0]        frame_cnt_reg, frame_cnt_next;
    logic [FC_W-1:0]   flash_cnt_reg, flash_cnt_next;
    logic [ADDR_W-1:0] layer_idx;
    logic              fg;
    logic              tint_on;
    logic [PIX_W-1:0]  tint_color;
    logic [PIX_W-1:0]  pix_next;
    logic [PIX_W-1:0]  rgb_reg;

    assign bundle = {frame_start, active, in_maze, pellet_pixel, power_pixel, win, game_over, sprite_pixel};
    assign {d_fs, d_active, d_in_maze, d_pellet, d_power, d_win, d_go, d_sprite} = dly;

    // Everything except the wall bit rides this shift register to meet the BRAM output.
    generate
        if (WALL_LAT == 0) begin : g_nodly
            assign dly = bundle;
        end else begin : g_dly
            for (genvar gi = 0; gi < WALL_LAT; gi++) begin : g_stage
                logic [BUN_W-1:0] q_reg;
                logic [BUN_W-1:0] d;
                if (gi == 0) begin : g_first
                    assign d = bundle;
                end else begin : g_chain
                    assign d = g_stage[gi-1].q_reg;
                end
                always_ff @(posedge clk_25MHz or negedge reset_n) begin
                    if (!reset_n) q_reg <= '0;
                    else          q_reg <= d;
                end
            end
            assign dly = g_stage[WALL_LAT-1].q_reg;
        end
    endgenerate

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PAL; i++) pal_reg[i] <= pal_default(i);
        end else begin
            for (int i = 0; i < NUM_PAL; i++)
                if (pal_we && pal_addr == ADDR_W'(i)) pal_reg[i] <= pal_data;
        end
    end

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= PLAY;
            frame_cnt_reg <= '0;
            flash_cnt_reg <= '0;
            rgb_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            flash_cnt_reg <= flash_cnt_next;
            rgb_reg       <= pix_next;
        end
    end

    // The *_next values feed the composite too, so the frame_start pixel already sees the new frame.
    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        flash_cnt_next = flash_cnt_reg;
        if (d_fs) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
            case (state_reg)
                PLAY: begin
                    if (d_win || d_go) begin
                        state_next     = FLASH;
                        flash_cnt_next = '0;
                    end
                end
                FLASH: begin
                    if (!(d_win || d_go))                          state_next = PLAY;
                    else if (flash_cnt_reg == FC_W'(FLASH_FRAMES - 1)) state_next = HOLD;
                    else                                           flash_cnt_next = flash_cnt_reg + 1'b1;
                end
                HOLD: begin
                    if (!(d_win || d_go)) state_next = PLAY;
                end
                default: state_next = PLAY;
            endcase
        end
    end

    always_comb begin
        layer_idx = '0;
        fg        = 1'b0;
        if (d_in_maze) begin
            if (|d_sprite) begin
                fg = 1'b1;
                for (int i = NUM_SPRITES - 1; i >= 0; i--)
                    if (d_sprite[i]) layer_idx = ADDR_W'(i + 4);
            end else if (wall_pixel) begin
                fg        = 1'b1;
                layer_idx = ADDR_W'(1);
            end else if (d_power && !frame_cnt_next[BLINK_BIT]) begin
                fg        = 1'b1;
                layer_idx = ADDR_W'(3);
            end else if (d_pellet) begin
                fg        = 1'b1;
                layer_idx = ADDR_W'(2);
            end
        end

        tint_on = (state_next == HOLD) ||
                  (state_next == FLASH &&
                   |((flash_cnt_next / FC_W'(FLASH_PERIOD)) & FC_W'(1)));
        if (d_win) tint_color = fg ? TINT_WIN_FG : TINT_WIN_BG;
        else       tint_color = fg ? TINT_LOSE_FG : TINT_LOSE_BG;

        if (!d_active)    pix_next = '0;
        else if (tint_on) pix_next = tint_color;
        else              pix_next = pal_reg[layer_idx];
    end

    assign {Red, Green, Blue} = rgb_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor (WALL_LAT=2): priority, latency, palette, blink,
// win/lose flash sequencing and asynchronous reset.
module tb_layer_compositor;
    logic        clk_25MHz = 1'b0;
    logic        reset_n;
    logic        frame_start, active, in_maze, wall_pixel, pellet_pixel, power_pixel;
    logic [3:0]  sprite_pixel;
    logic        win, game_over, pal_we;
    logic [2:0]  pal_addr;
    logic [11:0] pal_data;
    logic [3:0]  Red, Green, Blue;
    logic [1:0]  state;
    logic [11:0] pix;

    int checks   = 0;
    int failures = 0;

    assign pix = {Red, Green, Blue};

    always #5 clk_25MHz = ~clk_25MHz;

    layer_compositor #(
        .NUM_SPRITES(4), .COLOR_W(4), .WALL_LAT(2),
        .BLINK_BIT(4), .FLASH_PERIOD(8), .FLASH_FRAMES(64)
    ) dut (
        .clk_25MHz(clk_25MHz), .reset_n(reset_n), .frame_start(frame_start),
        .active(active), .in_maze(in_maze), .wall_pixel(wall_pixel),
        .pellet_pixel(pellet_pixel), .power_pixel(power_pixel), .sprite_pixel(sprite_pixel),
        .win(win), .game_over(game_over), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .Red(Red), .Green(Green), .Blue(Blue), .state(state)
    );

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    // Runs one 8-pixel frame: pixels 0-3 are wall, 4-7 background (wall bit leads by 2 cycles).
    task automatic run_frame(input logic w1, input logic g1, input int chg, input logic w2,
                             input logic g2, output logic [11:0] pw, output logic [11:0] pb,
                             output logic [1:0] st);
        pw = '0;
        pb = '0;
        for (int c = 0; c < 8; c++) begin
            frame_start = (c == 0);
            wall_pixel  = (c >= 2 && c <= 5);
            win         = (c >= chg) ? w2 : w1;
            game_over   = (c >= chg) ? g2 : g1;
            tick();
            if (c == 2) pw = pix;
            if (c == 6) pb = pix;
        end
        frame_start = 1'b0;
        wall_pixel  = 1'b0;
        st = state;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        frame_start = 0; active = 0; in_maze = 0; wall_pixel = 0; pellet_pixel = 0;
        power_pixel = 0; sprite_pixel = '0; win = 0; game_over = 0;
        pal_we = 0; pal_addr = '0; pal_data = '0;
        #23;
        checks++;
        if (pix !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h expected 000", pix); end
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (pix !== 12'h000) begin failures++; $display("FAIL reset_idle_rgb: got %h expected 000", pix); end
        $display("reset: rgb=%h state=%0d", pix, state);
    endtask

    task automatic test_priority();
        logic [20:0] rows [10];
        logic [20:0] r;
        active = 1; in_maze = 1;
        repeat (4) tick();
        checks++;
        if (pix !== 12'h000) begin failures++; $display("FAIL prio_bg: got %h expected 000", pix); end
        sprite_pixel = 4'b0001;
        repeat (2) tick();
        checks++;
        if (pix !== 12'h000) begin failures++; $display("FAIL prio_early: got %h expected 000 at t+2", pix); end
        tick();
        checks++;
        if (pix !== 12'hF00) begin failures++; $display("FAIL prio_lat: got %h expected F00 at t+3", pix); end
        // {sprite, wall, pellet, power, in_maze, active, expected rgb}
        rows[0] = {4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFF0};
        rows[1] = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h00F};
        rows[2] = {4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00F};
        rows[3] = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0F0};
        rows[4] = {4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF};
        rows[5] = {4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0FF};
        rows[6] = {4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hF0F};
        rows[7] = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        rows[8] = {4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
        rows[9] = {4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        for (int i = 0; i < 10; i++) begin
            r = rows[i];
            sprite_pixel = r[20:17];
            wall_pixel   = r[16];
            pellet_pixel = r[15];
            power_pixel  = r[14];
            in_maze      = r[13];
            active       = r[12];
            repeat (4) tick();
            checks++;
            if (pix !== r[11:0]) begin
                failures++;
                $display("FAIL prio_row%0d: got %h expected %h", i, pix, r[11:0]);
            end
            $display("priority row %0d: rgb=%h", i, pix);
        end
        sprite_pixel = '0; wall_pixel = 0; pellet_pixel = 0; power_pixel = 0;
        in_maze = 1; active = 1;
        repeat (4) tick();
    endtask

    task automatic test_latency();
        logic [11:0] exp;
        for (int mode = 0; mode < 2; mode++) begin
            pellet_pixel = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                tick();
                pellet_pixel = 1'b0;
                wall_pixel   = (mode == 0) && (k == 2);
                if (k == 3) exp = (mode == 0) ? 12'h00F : 12'h0F0;
                else        exp = 12'h000;
                checks++;
                if (pix !== exp) begin
                    failures++;
                    $display("FAIL latency_m%0d_t%0d: got %h expected %h", mode, k, pix, exp);
                end
            end
            wall_pixel = 1'b0;
            $display("latency mode %0d done", mode);
        end
    endtask

    task automatic test_palette();
        wall_pixel = 1'b1;
        repeat (4) tick();
        pal_we = 1; pal_addr = 3'd1; pal_data = 12'h0A5;
        tick();
        pal_we = 0;
        checks++;
        if (pix !== 12'h00F) begin failures++; $display("FAIL pal_same_edge: got %h expected 00F", pix); end
        tick();
        checks++;
        if (pix !== 12'h0A5) begin failures++; $display("FAIL pal_next: got %h expected 0A5", pix); end
        pal_we = 1; pal_data = 12'h111;
        tick();
        checks++;
        if (pix !== 12'h0A5) begin failures++; $display("FAIL pal_burst0: got %h expected 0A5", pix); end
        pal_data = 12'h222;
        tick();
        checks++;
        if (pix !== 12'h111) begin failures++; $display("FAIL pal_burst1: got %h expected 111", pix); end
        pal_data = 12'h333;
        tick();
        checks++;
        if (pix !== 12'h222) begin failures++; $display("FAIL pal_burst2: got %h expected 222", pix); end
        pal_we = 0;
        tick();
        checks++;
        if (pix !== 12'h333) begin failures++; $display("FAIL pal_last_wins: got %h expected 333", pix); end
        pal_we = 1; pal_data = 12'h00F;
        tick();
        pal_we = 0;
        wall_pixel = 1'b0;
        repeat (3) tick();
        $display("palette: restored wall entry");
    endtask

    task automatic test_blink();
        logic [7:0]  fc;
        logic [11:0] exp;
        fc = 8'd0;
        power_pixel = 1'b1;
        repeat (4) tick();
        checks++;
        if (pix !== 12'hFFF) begin failures++; $display("FAIL blink_f0: got %h expected FFF", pix); end
        for (int f = 1; f <= 40; f++) begin
            fc = fc + 8'd1;
            exp = fc[4] ? 12'h000 : 12'hFFF;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (2) tick();
            checks++;
            if (pix !== exp) begin failures++; $display("FAIL blink_first_f%0d: got %h expected %h", f, pix, exp); end
            repeat (5) tick();
            checks++;
            if (pix !== exp) begin failures++; $display("FAIL blink_last_f%0d: got %h expected %h", f, pix, exp); end
            $display("blink frame %0d: rgb=%h", f, pix);
        end
        power_pixel = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_win_flash();
        logic [11:0] pw, pb, ew, eb;
        logic [1:0]  st;
        logic        tinted;
        run_frame(1'b0, 1'b0, 4, 1'b1, 1'b0, pw, pb, st);
        checks++;
        if (st !== 2'd0 || pw !== 12'h00F || pb !== 12'h000) begin
            failures++;
            $display("FAIL win_pre: got st=%0d w=%h b=%h expected st=0 w=00F b=000", st, pw, pb);
        end
        for (int k = 0; k < 64; k++) begin
            run_frame(1'b1, 1'b0, 8, 1'b1, 1'b0, pw, pb, st);
            tinted = ((k / 8) % 2) == 1;
            ew = tinted ? 12'h0F0 : 12'h00F;
            eb = tinted ? 12'h040 : 12'h000;
            checks++;
            if (st !== 2'd1) begin failures++; $display("FAIL win_state_k%0d: got %0d expected 1", k, st); end
            checks++;
            if (pw !== ew) begin failures++; $display("FAIL win_wall_k%0d: got %h expected %h", k, pw, ew); end
            checks++;
            if (pb !== eb) begin failures++; $display("FAIL win_bg_k%0d: got %h expected %h", k, pb, eb); end
            $display("win flash frame %0d: st=%0d wall=%h bg=%h", k, st, pw, pb);
        end
        run_frame(1'b1, 1'b0, 8, 1'b1, 1'b0, pw, pb, st);
        checks++;
        if (st !== 2'd2 || pw !== 12'h0F0 || pb !== 12'h040) begin
            failures++;
            $display("FAIL win_hold: got st=%0d w=%h b=%h expected st=2 w=0F0 b=040", st, pw, pb);
        end
        run_frame(1'b0, 1'b1, 8, 1'b0, 1'b1, pw, pb, st);
        checks++;
        if (st !== 2'd2 || pw !== 12'hF00 || pb !== 12'h400) begin
            failures++;
            $display("FAIL hold_lose_tint: got st=%0d w=%h b=%h expected st=2 w=F00 b=400", st, pw, pb);
        end
        run_frame(1'b0, 1'b0, 8, 1'b0, 1'b0, pw, pb, st);
        checks++;
        if (st !== 2'd0 || pw !== 12'h00F || pb !== 12'h000) begin
            failures++;
            $display("FAIL win_exit: got st=%0d w=%h b=%h expected st=0 w=00F b=000", st, pw, pb);
        end
        $display("win exit: st=%0d wall=%h", st, pw);
    endtask

    task automatic test_lose_then_win();
        logic [11:0] pw, pb, ew, eb;
        logic [1:0]  st;
        logic        tinted, w;
        for (int k = 0; k <= 16; k++) begin
            w = (k >= 10);
            run_frame(w, 1'b1, 8, w, 1'b1, pw, pb, st);
            tinted = (k >= 8 && k <= 15);
            if (!tinted) begin ew = 12'h00F; eb = 12'h000; end
            else if (w)  begin ew = 12'h0F0; eb = 12'h040; end
            else         begin ew = 12'hF00; eb = 12'h400; end
            checks++;
            if (st !== 2'd1 || pw !== ew || pb !== eb) begin
                failures++;
                $display("FAIL lose_win_k%0d: got st=%0d w=%h b=%h expected st=1 w=%h b=%h",
                         k, st, pw, pb, ew, eb);
            end
            $display("lose/win flash frame %0d: st=%0d wall=%h bg=%h", k, st, pw, pb);
        end
        run_frame(1'b0, 1'b0, 8, 1'b0, 1'b0, pw, pb, st);
        checks++;
        if (st !== 2'd0) begin failures++; $display("FAIL lose_exit: got %0d expected 0", st); end
    endtask

    task automatic test_reset_midline();
        logic [11:0] pw, pb;
        logic [1:0]  st;
        pal_we = 1; pal_addr = 3'd1; pal_data = 12'h0A5;
        tick();
        pal_we = 0;
        for (int k = 0; k < 65; k++) run_frame(1'b0, 1'b1, 8, 1'b0, 1'b1, pw, pb, st);
        checks++;
        if (st !== 2'd2) begin failures++; $display("FAIL rst_pre_hold: got %0d expected 2", st); end
        wall_pixel = 1'b1; game_over = 1'b1;
        repeat (4) tick();
        checks++;
        if (pix !== 12'hF00) begin failures++; $display("FAIL rst_pre_rgb: got %h expected F00", pix); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pix !== 12'h000) begin failures++; $display("FAIL rst_async_rgb: got %h expected 000", pix); end
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL rst_async_state: got %0d expected 0", state); end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (pix !== 12'h00F) begin failures++; $display("FAIL rst_pal_default: got %h expected 00F", pix); end
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL rst_play_hold: got %0d expected 0", state); end
        wall_pixel = 1'b0;
        run_frame(1'b0, 1'b1, 8, 1'b0, 1'b1, pw, pb, st);
        checks++;
        if (st !== 2'd1 || pw !== 12'h00F) begin
            failures++;
            $display("FAIL rst_reflash: got st=%0d w=%h expected st=1 w=00F", st, pw);
        end
        run_frame(1'b0, 1'b0, 8, 1'b0, 1'b0, pw, pb, st);
        $display("reset midline: st=%0d wall=%h", st, pw);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_latency();
        test_palette();
        test_blink();
        test_win_flash();
        test_lose_then_win();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
